// File: rtl/nested_counter_pkg.sv
// Shared types for the nested (row/column) index sweeper.
package nested_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter: counts 0..lim-1 on en, wrapping to 0; at_lim flags the top value.
module wrap_counter #(
  parameter int nbits = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [nbits-1:0] lim,
  output logic [nbits-1:0] count_out,
  output logic             at_lim
);

  localparam logic [nbits-1:0] ONE = {{(nbits-1){1'b0}}, 1'b1};

  // A zero limit never matches, so an unloaded counter never reports at_lim.
  assign at_lim = (lim != '0) && (count_out == (lim - ONE));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_out <= '0;
    end else if (en) begin
      count_out <= at_lim ? '0 : (count_out + ONE);
    end
  end

endmodule

// File: rtl/nested_counter.sv
// Row-major (i,j) index sweeper with valid/ready output and abort.
// Handshake: a pair transfers on a rising edge where out_val && out_rdy; out_val never depends on out_rdy.
module nested_counter
  import nested_counter_pkg::*;
#(
  parameter int NBITS_I = 16,
  parameter int NBITS_J = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [NBITS_I-1:0] lim_i,
  input  logic [NBITS_J-1:0] lim_j,
  input  logic               out_rdy,
  output logic               out_val,
  output logic [NBITS_I-1:0] out_i,
  output logic [NBITS_J-1:0] out_j,
  output logic               out_last_j,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  state_e             state;
  logic [NBITS_I-1:0] lim_i_q;
  logic [NBITS_J-1:0] lim_j_q;
  logic               load;
  logic               zero_lim;
  logic               xfer;
  logic               en_i;
  logic               en_j;
  logic               at_i;
  logic               at_j;

  assign load     = (state == IDLE) && start && !abort;
  assign zero_lim = (lim_i == '0) || (lim_j == '0);
  // Abort outranks a transfer in the same cycle.
  assign xfer     = (state == RUN) && out_rdy && !abort;
  assign en_j     = xfer && !out_last;
  assign en_i     = xfer && at_j && !at_i;

  assign out_last_j = at_j;
  assign out_last   = at_i && at_j;
  assign out_val    = (state == RUN);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      lim_i_q <= '0;
      lim_j_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            lim_i_q <= lim_i;
            lim_j_q <= lim_j;
            state   <= zero_lim ? DONE : RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (xfer && out_last) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  wrap_counter #(.nbits(NBITS_I)) u_cnt_i (
    .clk       (clk),
    .reset     (reset),
    .clear     (load),
    .en        (en_i),
    .lim       (lim_i_q),
    .count_out (out_i),
    .at_lim    (at_i)
  );

  wrap_counter #(.nbits(NBITS_J)) u_cnt_j (
    .clk       (clk),
    .reset     (reset),
    .clear     (load),
    .en        (en_j),
    .lim       (lim_j_q),
    .count_out (out_j),
    .at_lim    (at_j)
  );

endmodule

// File: tb/tb_nested_counter.sv
// Directed bench for nested_counter: 16-bit instance plus a 2-bit instance at full-scale limits.
module tb_nested_counter;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] lim_i;
  logic [15:0] lim_j;
  logic        out_rdy;
  logic        out_val;
  logic [15:0] out_i;
  logic [15:0] out_j;
  logic        out_last_j;
  logic        out_last;
  logic        busy;
  logic        done;

  logic        start2;
  logic        abort2;
  logic [1:0]  lim_i2;
  logic [1:0]  lim_j2;
  logic        out_rdy2;
  logic        out_val2;
  logic [1:0]  out_i2;
  logic [1:0]  out_j2;
  logic        out_last_j2;
  logic        out_last2;
  logic        busy2;
  logic        done2;

  int          vectors;
  int          miscompares;
  logic [31:0] exp_q[$];

  nested_counter #(.NBITS_I(16), .NBITS_J(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .lim_i(lim_i), .lim_j(lim_j), .out_rdy(out_rdy),
    .out_val(out_val), .out_i(out_i), .out_j(out_j),
    .out_last_j(out_last_j), .out_last(out_last), .busy(busy), .done(done)
  );

  nested_counter #(.NBITS_I(2), .NBITS_J(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2),
    .lim_i(lim_i2), .lim_j(lim_j2), .out_rdy(out_rdy2),
    .out_val(out_val2), .out_i(out_i2), .out_j(out_j2),
    .out_last_j(out_last_j2), .out_last(out_last2), .busy(busy2), .done(done2)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_val"}, out_val, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Full sweep against a queue of expected row-major pairs; throttle gives out_rdy = 1,0,0,1,0,0,...
  task automatic run_sweep(input int li, input int lj, input bit throttle);
    logic [31:0] exp_pair;
    int c;
    exp_q.delete();
    for (int i = 0; i < li; i++)
      for (int j = 0; j < lj; j++)
        exp_q.push_back({i[15:0], j[15:0]});
    lim_i = li[15:0];
    lim_j = lj[15:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    lim_i = 16'd1;
    lim_j = 16'd1;
    c = 0;
    while (exp_q.size() > 0 && c < 200) begin
      out_rdy  = throttle ? (c % 3 == 0) : 1'b1;
      exp_pair = exp_q[0];
      check("sweep_val", out_val, 1);
      check("sweep_pair", {out_i, out_j}, exp_pair);
      check("sweep_last_j", out_last_j, (int'(exp_pair[15:0]) == lj - 1));
      check("sweep_last", out_last, (exp_q.size() == 1));
      check("sweep_done_early", done, 0);
      if (out_rdy) void'(exp_q.pop_front());
      tick();
      c++;
    end
    check("sweep_remaining", exp_q.size(), 0);
    out_rdy = 1'b1;
    check("sweep_done", done, 1);
    check("sweep_val_after", out_val, 0);
    check("sweep_busy_done", busy, 1);
    tick();
    check_idle_outputs("sweep_idle");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; lim_i = '0; lim_j = '0; out_rdy = 1'b1;
    start2 = 1'b0; abort2 = 1'b0; lim_i2 = '0; lim_j2 = '0; out_rdy2 = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;

    // Reset state
    check_idle_outputs("rst");
    check("rst_i", out_i, 0);
    check("rst_j", out_j, 0);
    check("rst_last", out_last, 0);
    check("rst_last_j", out_last_j, 0);

    // 2x3 back-to-back, then 2x2 with throttled ready
    run_sweep(2, 3, 1'b0);
    run_sweep(2, 2, 1'b1);

    // Zero limits: DONE for one cycle, nothing emitted
    lim_i = 16'd0; lim_j = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("zi_val", out_val, 0);
    check("zi_done", done, 1);
    check("zi_busy", busy, 1);
    tick();
    check_idle_outputs("zi_idle");
    lim_i = 16'd3; lim_j = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zj_val", out_val, 0);
    check("zj_done", done, 1);
    tick();
    check_idle_outputs("zj_idle");

    // Abort and start together in IDLE: stays idle
    lim_i = 16'd2; lim_j = 16'd2; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_idle_outputs("abst");
    tick();
    check_idle_outputs("abst2");

    // 3x4, abort while the 5th pair (1,0) is presented
    lim_i = 16'd3; lim_j = 16'd4; start = 1'b1; out_rdy = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("ab_pair", {out_i, out_j}, {16'(k / 4), 16'(k % 4)});
      check("ab_val", out_val, 1);
      if (k == 4) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    check_idle_outputs("ab_after");
    tick();
    check("ab_no_done", done, 0);
    run_sweep(3, 4, 1'b0);

    // 4x4 with ignored start mid-sweep, then reset at pair (2,1)
    lim_i = 16'd4; lim_j = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      start = 1'b0;
      check("rs_pair", {out_i, out_j}, {16'(k / 4), 16'(k % 4)});
      check("rs_last", out_last, 0);
      if (k == 4) begin
        start = 1'b1; lim_i = 16'd1; lim_j = 16'd1;
      end
      if (k < 9) tick();
    end
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("rs_mid");
    check("rs_i", out_i, 0);
    check("rs_j", out_j, 0);
    check("rs_last_after", out_last, 0);
    check("rs_last_j_after", out_last_j, 0);
    tick();
    check("rs_stay_idle", busy, 0);

    // 2-bit instance at all-ones limits: 9 pairs, max (2,2)
    lim_i2 = 2'd3; lim_j2 = 2'd3; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        check("n2_val", out_val2, 1);
        check("n2_pair", {out_i2, out_j2}, {i[1:0], j[1:0]});
        check("n2_last_j", out_last_j2, (j == 2));
        check("n2_last", out_last2, (i == 2 && j == 2));
        tick();
      end
    check("n2_done", done2, 1);
    check("n2_val_after", out_val2, 0);
    check("n2_hold_i", out_i2, 2);
    check("n2_hold_j", out_j2, 2);
    tick();
    check("n2_idle", busy2, 0);
    check("n2_done_clear", done2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nested_counter.md
NESTED_COUNTER -- requirements
Module: nested_counter

Interface
REQ-001 SHALL have parameter NBITS_I, default 16, width of outer (row) index and limit.
REQ-002 SHALL have parameter NBITS_J, default 16, width of inner (column) index and limit.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a sweep; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel a sweep in progress.
REQ-007 SHALL have port lim_i  input  NBITS_I  outer iteration count, sampled with start.
REQ-008 SHALL have port lim_j  input  NBITS_J  inner iteration count, sampled with start.
REQ-009 SHALL have port out_rdy  input  1  consumer accepts current index pair.
REQ-010 SHALL have port out_val  output  1  index pair valid.
REQ-011 SHALL have port out_i  output  NBITS_I  current outer index.
REQ-012 SHALL have port out_j  output  NBITS_J  current inner index.
REQ-013 SHALL have port out_last_j  output  1  out_j equals latched lim_j-1 (end of row).
REQ-014 SHALL have port out_last  output  1  final pair of the sweep.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse on normal sweep completion.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 IDLE: start=1 SHALL latch lim_i/lim_j, clear both indices, and go to RUN; if either limit is 0, SHALL go to DONE instead, with no pair emitted.
REQ-019 RUN: out_val SHALL be 1; a pair SHALL be transferred only when out_val and out_rdy are both 1.
REQ-020 On transfer with out_last_j=0, out_j SHALL increment by 1.
REQ-021 On transfer with out_last_j=1 and out_last=0, out_j SHALL wrap to 0 and out_i SHALL increment by 1.
REQ-022 On transfer with out_last=1, FSM SHALL go to DONE; indices SHALL hold.
REQ-023 With out_rdy=0, out_i, out_j and out_val SHALL hold stable (no drop, no skip).
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-025 start SHALL be ignored outside IDLE; limits SHALL not change mid-sweep.
REQ-026 abort=1 in RUN or DONE SHALL return the FSM to IDLE next cycle with done=0 and out_val=0; abort SHALL take priority over a simultaneous transfer.
REQ-027 abort and start together in IDLE: abort SHALL win; FSM stays IDLE.
REQ-028 Latency: first pair SHALL be valid the cycle after start; back-to-back pairs SHALL issue every cycle with out_rdy held 1.
REQ-029 A sweep SHALL emit exactly lim_i*lim_j pairs, in row-major order.
REQ-030 Limits at maximum (all ones) SHALL work without index overflow; indices SHALL never exceed limit-1.
REQ-031 out_val, done and busy SHALL be driven from registered state only, not combinationally from inputs.

Reset
REQ-032 reset=1 SHALL force state IDLE, out_i=0, out_j=0, latched limits=0, out_val=0, done=0, busy=0, out_last=0, out_last_j=0, overriding all other inputs including mid-sweep.

Structure
REQ-033 The FSM state enum (IDLE/RUN/DONE) SHALL live in the shared helper package.
REQ-034 SHALL instantiate sub-module wrap_counter (parameter nbits; ports clk, reset, clear, en, lim, count_out, at_lim) twice, once per index.

Verification
REQ-035 lim_i=2, lim_j=3, out_rdy=1 -> pairs (0,0)(0,1)(0,2)(1,0)(1,1)(1,2) on consecutive cycles; out_last_j at j=2; out_last at (1,2); done one cycle later.
REQ-036 lim_i=2, lim_j=2, out_rdy toggling 1,0,0,1,... -> same 4 pairs in order, each held stable while out_rdy=0; done only after the 4th transfer.
REQ-037 lim_i=0 or lim_j=0 with start -> no out_val; done pulses the cycle after start; busy high for that single cycle.
REQ-038 lim_i=3, lim_j=4, abort at the 5th pair -> out_val drops next cycle, done never asserts; new start then runs cleanly from (0,0).
REQ-039 reset asserted mid-sweep (lim 4x4, at pair (2,1)) -> all outputs 0 next cycle; start pulses during RUN are ignored.
REQ-040 NBITS_I=NBITS_J=2, lim_i=lim_j=3 -> 9 pairs, max index (2,2), no wrap past the limit.
